// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit time-multiplexed display scanner.
// Drives digit select/enable with inter-digit blanking.
module disp_scan_ctrl #(
    parameter int ON_TICKS    = 50000,
    parameter int BLANK_TICKS = 1000,
    parameter int CNT_W       = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [3:0] digit_en,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    input  logic [3:0] dp_in,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] hex_out,
    output logic       dp_out,
    output logic       frame_tick
);

    typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic HAS_BLANK = (BLANK_TICKS > 0);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       sel_n;
    logic             en_n;
    logic [3:0]       hex_n;
    logic             dp_n;
    logic             wrap;

    // Next state, dwell count, select and registered-output values
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        wrap    = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_n = ON;
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                end
            end
            ON: begin
                if (!run) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                end else if (cnt == ON_LAST) begin
                    cnt_n = '0;
                    if (HAS_BLANK) begin
                        state_n = BLANK;
                    end else begin
                        sel_n = sel + 2'd1;
                        wrap  = (sel == 2'd3);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BLANK: begin
                if (!run) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sel_n   = 2'd0;
                end else if (cnt == BLANK_LAST) begin
                    state_n = ON;
                    cnt_n   = '0;
                    sel_n   = sel + 2'd1;
                    wrap    = (sel == 2'd3);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                sel_n   = 2'd0;
            end
        endcase
        en_n = (state_n == ON) && digit_en[sel_n];
        unique case (sel_n)
            2'd0:    hex_n = hex0;
            2'd1:    hex_n = hex1;
            2'd2:    hex_n = hex2;
            default: hex_n = hex3;
        endcase
        dp_n = dp_in[sel_n];
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 2'd0;
            en         <= 1'b0;
            hex_out    <= 4'd0;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            en         <= en_n;
            hex_out    <= hex_n;
            dp_out     <= dp_n;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl.
// Instance dut uses ON=4/BLANK=2, instance dut0 uses ON=4/BLANK=0.
module tb_disp_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, run0;
    logic [3:0] digit_en;
    logic [3:0] hex0, hex1, hex2, hex3;
    logic [3:0] dp_in;
    logic [1:0] sel, sel0;
    logic       en, en0;
    logic [3:0] hex_out, hex_out0;
    logic       dp_out, dp_out0;
    logic       frame_tick, frame_tick0;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] hv [4];
    logic [3:0] mask;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.ON_TICKS(4), .BLANK_TICKS(2), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .digit_en(digit_en),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .dp_in(dp_in), .sel(sel), .en(en), .hex_out(hex_out),
        .dp_out(dp_out), .frame_tick(frame_tick)
    );

    disp_scan_ctrl #(.ON_TICKS(4), .BLANK_TICKS(0), .CNT_W(3)) dut0 (
        .clk(clk), .reset_n(reset_n), .run(run0), .digit_en(digit_en),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .dp_in(dp_in), .sel(sel0), .en(en0), .hex_out(hex_out0),
        .dp_out(dp_out0), .frame_tick(frame_tick0)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle c (1-based) after leaving IDLE on the BLANK=2 instance.
    task automatic scan_a(input int first, input int last, input int chg);
        for (int c = first; c <= last; c++) begin
            int k;
            int p;
            step();
            k = (c - 1) / 6;
            p = (c - 1) % 6;
            chk($sformatf("a_sel c%0d", c), 8'(sel), 8'(k % 4));
            chk($sformatf("a_en c%0d", c), 8'(en),
                8'((p < 4) && mask[k % 4]));
            chk($sformatf("a_hex c%0d", c), 8'(hex_out), 8'(hv[k % 4]));
            chk($sformatf("a_dp c%0d", c), 8'(dp_out), 8'(dp_in[k % 4]));
            chk($sformatf("a_ft c%0d", c), 8'(frame_tick),
                8'((p == 0) && (k > 0) && (k % 4 == 0)));
            if (c == chg) begin
                hex1  = 4'd9;
                hv[1] = 4'd9;
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        run      = 1'b1;
        run0     = 1'b0;
        digit_en = 4'hF;
        mask     = 4'hF;
        hex0 = 4'd1; hex1 = 4'd2; hex2 = 4'd3; hex3 = 4'd4;
        hv[0] = 4'd1; hv[1] = 4'd2; hv[2] = 4'd3; hv[3] = 4'd4;
        dp_in = 4'b0101;

        // Reset held with run=1: everything stays dark
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sel", 8'(sel), 8'd0);
            chk("rst_en", 8'(en), 8'd0);
            chk("rst_hex", 8'(hex_out), 8'd0);
            chk("rst_dp", 8'(dp_out), 8'd0);
            chk("rst_ft", 8'(frame_tick), 8'd0);
        end

        // Full scan, two frames plus a little
        reset_n = 1'b1;
        scan_a(1, 30, 0);

        // Masked positions 0 and 2 stay dark, slot timing unchanged
        mask     = 4'b1010;
        digit_en = mask;
        scan_a(31, 64, 0);

        // Cycle 64 is position 2 at ON expiry; run drop wins
        run = 1'b0;
        step();
        chk("stop_en", 8'(en), 8'd0);
        chk("stop_sel", 8'(sel), 8'd0);
        chk("stop_ft", 8'(frame_tick), 8'd0);
        chk("stop_hex", 8'(hex_out), 8'(hv[0]));
        step();
        chk("idle_en", 8'(en), 8'd0);
        chk("idle_sel", 8'(sel), 8'd0);

        // Restart from sel=0, no frame tick until second frame;
        // hex1 changes at cycle 8 (sel=1, mid ON)
        mask     = 4'hF;
        digit_en = mask;
        run      = 1'b1;
        scan_a(1, 26, 8);

        // Zero-blank instance: advance every 4 cycles, frame of 16
        chk("b_idle_en", 8'(en0), 8'd0);
        chk("b_idle_sel", 8'(sel0), 8'd0);
        run0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            int k;
            step();
            k = (c - 1) / 4;
            chk($sformatf("b_sel c%0d", c), 8'(sel0), 8'(k % 4));
            chk($sformatf("b_en c%0d", c), 8'(en0), 8'd1);
            chk($sformatf("b_hex c%0d", c), 8'(hex_out0), 8'(hv[k % 4]));
            chk($sformatf("b_ft c%0d", c), 8'(frame_tick0),
                8'(c == 17));
        end

        // Reset mid-scan wins over run
        reset_n = 1'b0;
        step();
        chk("rst2_en", 8'(en), 8'd0);
        chk("rst2_sel", 8'(sel), 8'd0);
        chk("rst2_hex", 8'(hex_out), 8'd0);
        chk("rst2_en0", 8'(en0), 8'd0);
        chk("rst2_sel0", 8'(sel0), 8'd0);
        chk("rst2_hex0", 8'(hex_out0), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
